addr_pipe_acc: RTL and testbench

- Next-generation successor of the chip's 4-bit registered adder.
- Parametrised operand width and channel count, with four arithmetic modes (add, subtract, accumulate, saturating accumulate).
- Independent per-channel accumulators, behind a 2-stage pipeline with valid/ready handshakes on both sides.
- Sits between the pad-ring input synchronisers and the output pad drivers in the APP top level.

---
 rtl/addr_pkg.sv | 30 +++
 rtl/addr_acc_bank.sv | 30 +++
 rtl/addr_pipe_acc.sv | 116 +++++++++++
 tb/tb_addr_pipe_acc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/addr_pkg.sv
// Shared mode encoding and the wrap/saturate accumulator helper for addr_pipe_acc.
package addr_pkg;

    typedef enum logic [1:0] {
        MODE_ADD     = 2'd0,
        MODE_SUB     = 2'd1,
        MODE_ACC     = 2'd2,
        MODE_ACC_SAT = 2'd3
    } mode_e;

    // Result occupies bits [acc_w-1:0] and the overflow flag sits at bit acc_w,
    // so the caller recovers {ovf, result} with a single (acc_w+1)-bit cast.
    function automatic logic [63:0] sat_add(
        input logic [63:0] acc,
        input logic [63:0] sum,
        input logic        sat,
        input logic [5:0]  acc_w
    );
        logic [63:0] n;
        logic [63:0] mask;
        logic [63:0] res;
        logic        carry;
        n     = acc + sum;
        mask  = (64'd1 << acc_w) - 64'd1;
        carry = n[acc_w];
        res   = (sat && carry) ? mask : (n & mask);
        return res | (64'(carry) << acc_w);
    endfunction

endpackage

// File: rtl/addr_acc_bank.sv
// Per-channel accumulator storage: NCH x ACC_W registers, one async read, one write.
module addr_acc_bank #(
    parameter int NCH   = 4,
    parameter int ACC_W = 8,
    parameter int CH_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH_W-1:0]  rd_chan,
    output logic [ACC_W-1:0] rd_data,
    input  logic             we,
    input  logic [CH_W-1:0]  wr_chan,
    input  logic [ACC_W-1:0] wr_data
);

    logic [ACC_W-1:0] acc_q [NCH];

    assign rd_data = acc_q[rd_chan];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
            end
        end else if (we) begin
            acc_q[wr_chan] <= wr_data;
        end
    end

endmodule

// File: rtl/addr_pipe_acc.sv
// Two-stage add/sub/accumulate pipeline with valid/ready on both sides and
// per-channel accumulators updated on the same edge that registers the result.
module addr_pipe_acc
    import addr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int ACC_W = 8,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       mode_i,
    input  logic [CH_W-1:0]  chan_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] c_o,
    output logic [CH_W-1:0]  out_chan_o,
    output logic             ovf_o
);

    logic             s1_valid;
    mode_e            s1_mode;
    logic [CH_W-1:0]  s1_chan;
    logic             s1_clr;
    logic [WIDTH:0]   s1_sum;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_adv;
    logic [ACC_W-1:0] acc_rd;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] res_c;
    logic             res_ovf;
    logic             acc_we;

    // The output register is stage 2, so its valid doubles as s2_valid.
    assign s2_adv     = !out_valid_o || out_ready_i;
    assign in_ready_o = !s1_valid || s2_adv;
    assign acc_base   = s1_clr ? '0 : acc_rd;

    always_comb begin
        res_c   = ACC_W'(s1_sum);
        res_ovf = 1'b0;
        acc_we  = 1'b0;
        case (s1_mode)
            MODE_ADD: ;
            MODE_SUB: begin
                res_c   = ACC_W'(s1_a) - ACC_W'(s1_b);
                res_ovf = s1_a < s1_b;
            end
            MODE_ACC, MODE_ACC_SAT: begin
                {res_ovf, res_c} = (ACC_W+1)'(sat_add(64'(acc_base), 64'(s1_sum),
                                                      s1_mode == MODE_ACC_SAT, 6'(ACC_W)));
                acc_we = s1_valid && s2_adv;
            end
            default: ;
        endcase
    end

    addr_acc_bank #(
        .NCH   (NCH),
        .ACC_W (ACC_W),
        .CH_W  (CH_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .rd_chan (s1_chan),
        .rd_data (acc_rd),
        .we      (acc_we),
        .wr_chan (s1_chan),
        .wr_data (res_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_mode     <= MODE_ADD;
            s1_chan     <= '0;
            s1_clr      <= 1'b0;
            s1_sum      <= '0;
            s1_a        <= '0;
            s1_b        <= '0;
            out_valid_o <= 1'b0;
            c_o         <= '0;
            out_chan_o  <= '0;
            ovf_o       <= 1'b0;
        end else begin
            if (in_ready_o) begin
                s1_valid <= in_valid_i;
                if (in_valid_i) begin
                    s1_mode <= mode_e'(mode_i);
                    s1_chan <= chan_i;
                    s1_clr  <= clr_i;
                    s1_sum  <= (WIDTH+1)'(a_i) + (WIDTH+1)'(b_i);
                    s1_a    <= a_i;
                    s1_b    <= b_i;
                end
            end
            if (s2_adv) begin
                out_valid_o <= s1_valid;
                if (s1_valid) begin
                    c_o        <= res_c;
                    out_chan_o <= s1_chan;
                    ovf_o      <= res_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_addr_pipe_acc.sv
// Directed + random bench for addr_pipe_acc against an arithmetic reference model.
module tb_addr_pipe_acc;

    localparam int WIDTH = 4;
    localparam int NCH   = 4;
    localparam int ACC_W = 8;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [CH_W-1:0]  chan;
    logic             clr;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] c_out;
    logic [CH_W-1:0]  out_chan;
    logic             ovf;

    always #5 clk = ~clk;

    addr_pipe_acc #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .ACC_W (ACC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mode_i      (mode),
        .chan_i      (chan),
        .clr_i       (clr),
        .a_i         (a_in),
        .b_i         (b_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .c_o         (c_out),
        .out_chan_o  (out_chan),
        .ovf_o       (ovf)
    );

    typedef struct {
        logic [7:0] c;
        logic [1:0] ch;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   acc_m[NCH];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    logic ok;
    logic ov;
    int   idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: items leave in arrival order, so the accumulator can be
    // updated at acceptance time.
    task automatic model_push(input logic [1:0] m, input logic [1:0] ch, input logic cl,
                              input int a, input int b);
        exp_t e;
        int   n;
        e.ch = ch;
        case (m)
            2'd0: begin
                e.c   = 8'(a + b);
                e.ovf = 1'b0;
            end
            2'd1: begin
                e.c   = 8'((a - b) & 255);
                e.ovf = (a < b);
            end
            default: begin
                n = (cl ? 0 : acc_m[ch]) + a + b;
                if (n > 255) begin
                    e.ovf = 1'b1;
                    e.c   = (m == 2'd3) ? 8'hFF : 8'(n - 256);
                end else begin
                    e.ovf = 1'b0;
                    e.c   = 8'(n);
                end
                acc_m[ch] = int'(e.c);
            end
        endcase
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                chk("c_o", 32'(c_out), 32'(exp_q[0].c));
                chk("out_chan_o", 32'(out_chan), 32'(exp_q[0].ch));
                chk("ovf_o", 32'(ovf), 32'(exp_q[0].ovf));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    endtask

    // One clock: apply inputs after a falling edge, sample 1 ns later, end on next falling edge.
    task automatic step(input logic v, input logic [1:0] m, input logic [1:0] ch, input logic cl,
                        input logic [3:0] a, input logic [3:0] b, input logic ordy,
                        output logic acc_ok, output logic ov_seen);
        in_valid  = v;
        mode      = m;
        chan      = ch;
        clr       = cl;
        a_in      = a;
        b_in      = b;
        out_ready = ordy;
        #1;
        ov_seen = out_valid;
        check_out();
        acc_ok = v && (in_ready === 1'b1);
        if (acc_ok) model_push(m, ch, cl, int'(a), int'(b));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] m, input logic [1:0] ch, input logic cl,
                        input logic [3:0] a, input logic [3:0] b);
        logic k;
        logic o;
        k = 1'b0;
        for (int i = 0; i < 20 && !k; i++) step(1'b1, m, ch, cl, a, b, 1'b1, k, o);
        chk("send_accept", 32'(k), 32'd1);
    endtask

    task automatic drain();
        logic k;
        logic o;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) step(1'b0, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 1'b1, k, o);
        repeat (2) step(1'b0, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 1'b1, k, o);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; mode = 2'd0; chan = '0; clr = 1'b0;
        a_in = '0; b_in = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c_o", 32'(c_out), 32'd0);
        chk("rst_out_chan", 32'(out_chan), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // ADD 15+15: two-cycle latency, one-cycle valid pulse; clr is ignored
        step(1'b1, 2'd0, 2'd1, 1'b1, 4'd15, 4'd15, 1'b1, ok, ov);
        chk("add_accept", 32'(ok), 32'd1);
        step(1'b0, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 1'b1, ok, ov);
        chk("add_lat1", 32'(ov), 32'd0);
        step(1'b0, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 1'b1, ok, ov);
        chk("add_lat2", 32'(ov), 32'd1);
        step(1'b0, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 1'b1, ok, ov);
        chk("add_pulse", 32'(ov), 32'd0);

        send(2'd1, 2'd0, 1'b0, 4'd3, 4'd5);
        send(2'd1, 2'd3, 1'b1, 4'd9, 4'd4);
        drain();

        // ACC ch2: clear to 20, then +7 until it wraps at item 35
        send(2'd2, 2'd2, 1'b1, 4'd10, 4'd10);
        for (int i = 0; i < 34; i++) send(2'd2, 2'd2, 1'b0, 4'd7, 4'd0);
        send(2'd2, 2'd0, 1'b0, 4'd0, 4'd0);
        drain();

        // ACC_SAT ch1: climbs by 30, pins at 255, clr restarts
        for (int i = 0; i < 10; i++) send(2'd3, 2'd1, 1'b0, 4'd15, 4'd15);
        send(2'd3, 2'd1, 1'b1, 4'd1, 4'd1);
        drain();

        // Backpressure: five stalled cycles admit exactly two items
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'd0, 2'd2, 1'b0, 4'(idx + 1), 4'(idx), 1'b0, ok, ov);
            if (ok) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        while (idx < 6) begin
            send(2'd0, 2'd2, 1'b0, 4'(idx + 1), 4'(idx));
            idx++;
        end
        drain();

        // Reset with both stages full discards everything, accumulators included
        step(1'b1, 2'd2, 2'd3, 1'b1, 4'd5, 4'd5, 1'b0, ok, ov);
        chk("full_accept1", 32'(ok), 32'd1);
        step(1'b1, 2'd2, 2'd3, 1'b0, 4'd1, 4'd1, 1'b0, ok, ov);
        chk("full_accept2", 32'(ok), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_c_o", 32'(c_out), 32'd0);
        chk("midrst_out_chan", 32'(out_chan), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        exp_q.delete();
        for (int i = 0; i < NCH; i++) acc_m[i] = 0;
        @(negedge clk);
        rst = 1'b0;
        send(2'd2, 2'd3, 1'b0, 4'd2, 4'd3);
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, ok, ov);
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
